data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the cpu data port and data_memory.
//  Serves byte-wide cpu loads/stores (lwd/lwi/swd/swi) from an on-chip line array.
//  Stalls the cpu through BUSYWAIT on misses and moves whole 4-byte blocks to and from data_memory.
// PARAMETERS
//  LINES      8   number of cache lines; power of 2. INDEX_BITS=log2(LINES), TAG_BITS=6-INDEX_BITS
//  BLOCK_BYTES 4  fixed; offset = ADDRESS[1:0]
// PORTS
//  CLK            in   1   system clock, all state updates on posedge
//  RESET          in   1   asynchronous, active-low reset
//  READ           in   1   cpu load request
//  WRITE          in   1   cpu store request
//  ADDRESS        in   8   cpu byte address {tag, index, offset[1:0]}
//  WRITEDATA      in   8   cpu store data
//  READDATA       out  8   cpu load data
//  BUSYWAIT       out  1   stall cpu while high
//  mem_read       out  1   block read request to data_memory
//  mem_write      out  1   block write request to data_memory
//  mem_address    out  6   block address {tag, index}
//  mem_writedata  out  32  evicted block, byte0 in [7:0]
//  mem_readdata   in   32  fetched block, byte0 in [7:0]
//  mem_busywait   in   1   data_memory busy; request complete on its falling edge
// BEHAVIOUR
//  - Line state: valid, dirty, tag[TAG_BITS-1:0], data[31:0]. tag/index taken from ADDRESS[7:2].
//  - hit = valid[index] && tag[index]==ADDRESS tag. Evaluated combinationally.
//  - BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit). Combinational, no added delay.
//  - Read hit: READDATA = selected byte of line, combinational. No state change.
//  - Write hit: on the posedge, write WRITEDATA into the addressed byte and set dirty=1.
//  - The cpu holds READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT is high.
//  - READ&WRITE both high: treated as WRITE.
//  - READDATA = 8'h00 when READ is low.
//  - FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
//    IDLE: on a miss, go to WRITE_BACK if valid&dirty, else go to MEM_READ.
//    WRITE_BACK: mem_write=1, mem_address={old tag,index}, mem_writedata=line data.
//      Go to MEM_READ on the first posedge with mem_busywait low after it was seen high.
//    MEM_READ: mem_read=1, mem_address=ADDRESS[7:2]. Same completion rule, then go to UPDATE.
//    UPDATE: on one posedge, line data=mem_readdata, tag=new tag, valid=1, dirty=0; go to IDLE.
//      The access then hits: a read returns data in IDLE; a write writes and sets dirty=1 on the next posedge.
//  - Miss cost (clean) = memory latency + 2 cycles. A dirty miss adds one full memory write latency.
//  - mem_read and mem_write are never high together. Both are low in IDLE and UPDATE.
//  - No request (READ=WRITE=0): FSM stays IDLE and BUSYWAIT=0.
//  - Reset (RESET=0, any time, including mid-miss):
//    all valid/dirty=0, state=IDLE, mem_read=mem_write=0, BUSYWAIT follows the IDLE rule.
//    An in-flight memory transfer is abandoned and dirty contents are lost. Data arrays need not clear.
//  - Line tag/data only change in UPDATE or on a write hit.
// TESTING
//  1 Reset then READ 0x04 (cold):
//    BUSYWAIT=1, no WRITE_BACK, mem_read with mem_address=6'h01.
//    After UPDATE, READDATA=mem byte 4 and BUSYWAIT=0.
//  2 WRITE 0x05=8'hAB after test 1:
//    Zero-stall hit; line 1 byte1=AB, dirty=1, no memory traffic.
//    READ 0x05 then returns AB combinationally.
//  3 READ 0x24 (same index 1, tag 1) after test 2:
//    WRITE_BACK to mem_address=6'h01 with byte1=AB, then MEM_READ from 6'h09.
//    Line becomes tag1, dirty=0; memory byte 5 == AB.
//  4 Write-miss allocate: WRITE 0x10=8'h07 cold:
//    MEM_READ 6'h04, then the byte is written and dirty=1.
//    A later READ 0x10 returns 07 with no stall.
//  5 Assert RESET low during MEM_READ of test 4:
//    mem_read drops asynchronously and state=IDLE.
//    Next READ 0x10 misses again.
//  6 Hold READ=WRITE=0 for 20 cycles: BUSYWAIT, mem_read and mem_write all stay 0.

Source files
------------

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache
module data_cache #(
  parameter int LINES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_MEM_READ   = 2'd2,
    S_UPDATE     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Line state: valid/dirty are reset, tag/data are left as they are.
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Set once data_memory has raised busywait for the current transfer.
  logic r_busy_seen;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_offset;
  logic                  w_req;
  logic                  w_hit;
  logic [31:0]           w_line;
  logic [7:0]            w_byte;
  logic                  w_mem_done;
  logic                  w_write_hit;

  assign w_tag    = ADDRESS[7:2+INDEX_BITS];
  assign w_index  = ADDRESS[1+INDEX_BITS:2];
  assign w_offset = ADDRESS[1:0];
  assign w_req    = READ | WRITE;

  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line = r_data[w_index];
  assign w_byte = w_line[{w_offset, 3'b000} +: 8];

  // A transfer finishes on the first edge that sees busywait low after it was high.
  assign w_mem_done = r_busy_seen && !mem_busywait;

  // READ and WRITE together behave as a store.
  assign w_write_hit = (r_state == S_IDLE) && WRITE && w_hit;

  assign BUSYWAIT = w_req && !((r_state == S_IDLE) && w_hit);
  assign READDATA = READ ? w_byte : 8'h00;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next_state = S_WRITE_BACK;
          end else begin
            w_next_state = S_MEM_READ;
          end
        end
      end
      S_WRITE_BACK: begin
        if (w_mem_done) begin
          w_next_state = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (w_mem_done) begin
          w_next_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs decoded from the current state
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'h00;
    mem_writedata = 32'h0000_0000;
    case (r_state)
      S_WRITE_BACK: begin
        mem_write     = 1'b1;
        mem_address   = {r_tag[w_index], w_index};
        mem_writedata = w_line;
      end
      S_MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = ADDRESS[7:2];
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Track busywait within each memory transfer; cleared between transfers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_busy_seen <= 1'b0;
    end else if ((r_state == S_WRITE_BACK) || (r_state == S_MEM_READ)) begin
      r_busy_seen <= w_mem_done ? 1'b0 : (r_busy_seen | mem_busywait);
    end else begin
      r_busy_seen <= 1'b0;
    end
  end

  // Valid/dirty bookkeeping: fill marks clean, store hit marks dirty
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag/data array: block fill on UPDATE, single-byte merge on store hit
  always_ff @(posedge CLK) begin
    if (r_state == S_UPDATE) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_readdata;
    end else if (w_write_hit) begin
      r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache
module tb_data_cache;

  localparam int LAT     = 4;        // negedges busywait stays high per transfer
  localparam int MEM_CYC = LAT + 1;  // cycles from request to completion edge

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_busywait = 1'b0;

  int checks = 0;
  int failures = 0;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Behavioural data_memory responding on negedges
  logic [7:0]  mem_bytes [256];
  int          m_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          both_hi = 0;
  logic [5:0]  last_rd_addr = 6'h3f;
  logic [5:0]  last_wr_addr = 6'h3f;
  logic [31:0] last_wr_data = 32'h0;

  always @(negedge CLK) begin
    if (mem_read && mem_write) both_hi++;
    if (mem_busywait) begin
      if (!mem_read && !mem_write) begin
        mem_busywait = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          for (int k = 0; k < 4; k++) begin
            if (mem_write) mem_bytes[int'(mem_address) * 4 + k] = mem_writedata[8*k +: 8];
            else mem_readdata[8*k +: 8] = mem_bytes[int'(mem_address) * 4 + k];
          end
          mem_busywait = 1'b0;
        end
      end
    end else if (mem_read || mem_write) begin
      mem_busywait = 1'b1;
      m_cnt = LAT;
      if (mem_write) begin
        wr_count++;
        last_wr_addr = mem_address;
        last_wr_data = mem_writedata;
      end else begin
        rd_count++;
        last_rd_addr = mem_address;
      end
    end
  end

  // Reference cache: byte-level lines and a byte-level memory image
  bit         ref_valid [8];
  bit         ref_dirty [8];
  int         ref_tag   [8];
  logic [7:0] ref_line  [8][4];
  logic [7:0] ref_mem   [256];

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
    end
  endtask

  task automatic ref_access(input bit is_wr, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int stall, output int nwb, output int nrd);
    int idx, tg, off;
    idx = int'(a) / 4 % 8;
    tg  = int'(a) / 32;
    off = int'(a) % 4;
    stall = 0; nwb = 0; nrd = 0; rd = 8'h00;
    if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        for (int k = 0; k < 4; k++) ref_mem[(ref_tag[idx] * 8 + idx) * 4 + k] = ref_line[idx][k];
        nwb = 1;
        stall += MEM_CYC;
      end
      for (int k = 0; k < 4; k++) ref_line[idx][k] = ref_mem[(tg * 8 + idx) * 4 + k];
      ref_valid[idx] = 1;
      ref_dirty[idx] = 0;
      ref_tag[idx] = tg;
      nrd = 1;
      stall += MEM_CYC + 2;
    end
    if (is_wr) begin
      ref_line[idx][off] = wd;
      ref_dirty[idx] = 1;
    end else begin
      rd = ref_line[idx][off];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cpu access; called and returns at posedge+1
  task automatic cpu_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rdata, output int stall, output bit busy0);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    #1;
    busy0 = BUSYWAIT;
    stall = 0;
    while (BUSYWAIT && stall < 200) begin
      @(posedge CLK); #1;
      stall++;
    end
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic run(input string tag, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    logic [7:0] e_rd, o_rd;
    int e_st, o_st, e_wb, e_rdn, wb0, rd0;
    bit b0;
    wb0 = wr_count; rd0 = rd_count;
    ref_access(wr, a, wd, e_rd, e_st, e_wb, e_rdn);
    cpu_access(rd, wr, a, wd, o_rd, o_st, b0);
    chk({tag, "_busy"}, 32'(b0), 32'(e_st != 0));
    chk({tag, "_stall"}, o_st, e_st);
    if (rd && !wr) chk({tag, "_rdata"}, o_rd, e_rd);
    chk({tag, "_wbcount"}, wr_count - wb0, e_wb);
    chk({tag, "_rdcount"}, rd_count - rd0, e_rdn);
    #1;
    chk({tag, "_rdlow"}, READDATA, 8'h00);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    ref_clear();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, wd;
    int op, w, bad;

    for (int i = 0; i < 256; i++) begin
      mem_bytes[i] = 8'($urandom);
      ref_mem[i] = mem_bytes[i];
    end
    mem_bytes[8'h10] = 8'h3c;
    ref_mem[8'h10] = 8'h3c;
    ref_clear();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", BUSYWAIT, 1'b0);
    chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rst_rdata", READDATA, 8'h00);
    RESET = 1'b1;

    // 1: cold read
    run("t1", 1, 0, 8'h04, 8'h00);
    chk("t1_rdaddr", last_rd_addr, 6'h01);

    // 2: zero-stall write hit then read back
    run("t2w", 0, 1, 8'h05, 8'hab);
    run("t2r", 1, 0, 8'h05, 8'h00);

    // 3: conflicting read forces write-back of the dirty line
    run("t3", 1, 0, 8'h24, 8'h00);
    chk("t3_wbaddr", last_wr_addr, 6'h01);
    chk("t3_wbbyte1", last_wr_data[15:8], 8'hab);
    chk("t3_rdaddr", last_rd_addr, 6'h09);
    chk("t3_mem5", mem_bytes[5], 8'hab);
    run("t3clean", 1, 0, 8'h04, 8'h00);

    // 4: write-miss allocate
    run("t4w", 0, 1, 8'h10, 8'h07);
    chk("t4_rdaddr", last_rd_addr, 6'h04);
    run("t4r", 1, 0, 8'h10, 8'h00);

    // 5: reset in the middle of a block fetch
    do_reset();
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h10; WRITEDATA = 8'h55;
    w = 0;
    #1;
    while (!mem_read && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    chk("t5_mr_seen", mem_read, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk("t5_mem_rw_drop", {mem_read, mem_write}, 2'b00);
    chk("t5_busy_idle_miss", BUSYWAIT, 1'b1);
    WRITE = 1'b0;
    #1;
    chk("t5_busy_noreq", BUSYWAIT, 1'b0);
    ref_clear();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    run("t5r", 1, 0, 8'h10, 8'h00);

    // 6: idle hold
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      chk("t6_idle", {BUSYWAIT, mem_read, mem_write}, 3'b000);
    end

    // Random mix of loads, stores and conflicts
    for (int i = 0; i < 80; i++) begin
      a  = 8'($urandom & 32'h7f);
      wd = 8'($urandom);
      op = $urandom_range(0, 3);
      case (op)
        0, 1: run("rnd_rd", 1, 0, a, wd);
        2:    run("rnd_wr", 0, 1, a, wd);
        default: run("rnd_rw", 1, 1, a, wd);
      endcase
    end

    chk("mem_rw_exclusive", both_hi, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem_bytes[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
